// File: rtl/ternary_neuron_acc_pkg.sv
// Shared types and helpers for the ternary neuron accumulator.
// Holds activation codes, FSM states and the popcount delta function.
package ternary_nn_pkg;

  localparam logic [1:0] ACT_POS  = 2'b01;
  localparam logic [1:0] ACT_ZERO = 2'b00;
  localparam logic [1:0] ACT_NEG  = 2'b11;

  localparam int DELTA_W = 16;

  typedef enum logic {
    ST_ACC,
    ST_OUT
  } state_e;

  // Callers zero-extend popcounts to DELTA_W and keep the low bits.
  function automatic logic signed [DELTA_W-1:0] pop_delta(
    input logic [DELTA_W-1:0] pos,
    input logic [DELTA_W-1:0] neg
  );
    return $signed(pos - neg);
  endfunction

endpackage

// File: rtl/ternary_neuron_acc_if.sv
// Beat input / activation output handshake bundle.
// slave = accumulator side, master = producer/consumer side.
interface ternary_neuron_acc_if #(
  parameter int CNT_W = 5,
  parameter int ACC_W = 8
);

  logic                    in_valid;
  logic                    in_ready;
  logic [CNT_W-1:0]        pos_cnt;
  logic [CNT_W-1:0]        neg_cnt;
  logic signed [ACC_W-1:0] thr_hi;
  logic signed [ACC_W-1:0] thr_lo;
  logic                    out_valid;
  logic                    out_ready;
  logic [1:0]              act;
  logic signed [ACC_W-1:0] acc_out;

  modport slave (
    input  in_valid,
    input  pos_cnt,
    input  neg_cnt,
    input  thr_hi,
    input  thr_lo,
    input  out_ready,
    output in_ready,
    output out_valid,
    output act,
    output acc_out
  );

  modport master (
    output in_valid,
    output pos_cnt,
    output neg_cnt,
    output thr_hi,
    output thr_lo,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  act,
    input  acc_out
  );

endinterface

// File: rtl/ternary_act_cmp.sv
// Combinational sum-vs-threshold activation comparator.
// TERNARY_NEURON_TERNARY_ACT_EN selects ternary; default is binary sign.
module ternary_act_cmp
  import ternary_nn_pkg::*;
#(
  parameter int ACC_W = 8
) (
  input  logic signed [ACC_W-1:0] sum,
  input  logic signed [ACC_W-1:0] thr_hi,
  input  logic signed [ACC_W-1:0] thr_lo,
  output logic [1:0]              act
);

`ifdef TERNARY_NEURON_TERNARY_ACT_EN
  logic gt;
  logic lt;

  // lt masked by gt so the select stays one-hot even if thr_lo > thr_hi.
  assign gt = sum > thr_hi;
  assign lt = (sum < thr_lo) && !gt;

  always_comb begin
    act = ACT_ZERO;
    unique case (1'b1)
      gt:      act = ACT_POS;
      lt:      act = ACT_NEG;
      default: act = ACT_ZERO;
    endcase
  end
`else
  logic unused_thr_lo;

  assign unused_thr_lo = ^thr_lo;

  always_comb begin
    act = ACT_ZERO;
    if (sum >= thr_hi)
      act = ACT_POS;
  end
`endif

endmodule

// File: rtl/ternary_neuron_acc.sv
// Multi-beat signed popcount accumulator with ternary/binary activation.
// Activation mode chosen by TERNARY_NEURON_TERNARY_ACT_EN in ternary_act_cmp.
module ternary_neuron_acc
  import ternary_nn_pkg::*;
#(
  parameter int BEATS = 4,
  parameter int CNT_W = 5,
  parameter int ACC_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  ternary_neuron_acc_if.slave bus
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_e state;
  state_e state_nxt;

  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   sum;
  logic signed [ACC_W-1:0]   acc_out_q;
  logic signed [DELTA_W-1:0] delta;
  logic [CNT_W-1:0]          pos_w;
  logic [CNT_W-1:0]          neg_w;
  logic [BW-1:0]             beat_cnt;
  logic [1:0]                act_q;
  logic [1:0]                act_c;
  logic                      accept;
  logic                      last;

  assign pos_w = bus.pos_cnt;
  assign neg_w = bus.neg_cnt;

  assign delta = pop_delta(DELTA_W'(pos_w),
                           DELTA_W'(neg_w));

  // Wraps modulo 2^ACC_W by construction.
  assign sum = acc + $signed(delta[ACC_W-1:0]);

  assign accept = bus.in_valid && (state == ST_ACC);
  assign last   = (beat_cnt == BW'(BEATS - 1));

  ternary_act_cmp #(
    .ACC_W (ACC_W)
  ) u_cmp (
    .sum    (sum),
    .thr_hi (bus.thr_hi),
    .thr_lo (bus.thr_lo),
    .act    (act_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_ACC;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_ACC:
        if (accept && last)
          state_nxt = ST_OUT;
      ST_OUT:
        if (bus.out_ready)
          state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      beat_cnt  <= '0;
      act_q     <= ACT_ZERO;
      acc_out_q <= '0;
    end else if (accept) begin
      if (last) begin
        acc       <= '0;
        beat_cnt  <= '0;
        act_q     <= act_c;
        acc_out_q <= sum;
      end else begin
        acc      <= sum;
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  assign bus.in_ready  = (state == ST_ACC);
  assign bus.out_valid = (state == ST_OUT);
  assign bus.act       = act_q;
  assign bus.acc_out   = acc_out_q;

endmodule

// File: tb/tb_ternary_neuron_acc.sv
// Scoreboard bench for ternary_neuron_acc.
// Expectations follow TERNARY_NEURON_TERNARY_ACT_EN when defined.
module tb_ternary_neuron_acc;

  localparam int BEATS = 4;
  localparam int CNT_W = 5;
  localparam int ACC_W = 8;
  localparam int NCASE = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ternary_neuron_acc_if #(
    .CNT_W (CNT_W),
    .ACC_W (ACC_W)
  ) bus ();

  ternary_neuron_acc #(
    .BEATS (BEATS),
    .CNT_W (CNT_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int thr_hi_i;
  int thr_lo_i;
  int bp[BEATS];
  int bn[BEATS];
  logic [9:0] sb[$];
  logic [9:0] bb_ref;

  int case_p[NCASE][BEATS] = '{
    '{20, 20, 20, 20}, '{3, 3, 3, 3},
    '{7, 8, 5, 2},     '{7, 8, 5, 2},
    '{0, 0, 0, 0},     '{31, 31, 31, 31},
    '{31, 31, 31, 31}, '{3, 3, 3, 3}
  };
  int case_n[NCASE][BEATS] = '{
    '{5, 5, 5, 5},     '{9, 9, 9, 9},
    '{7, 6, 9, 0},     '{7, 6, 9, 0},
    '{31, 31, 31, 31}, '{0, 0, 0, 0},
    '{0, 0, 0, 0},     '{9, 9, 9, 9}
  };
  int case_hi[NCASE] = '{10, 10, 10, 0, 10, 124, 123, 10};
  int case_lo[NCASE] = '{-10, -10, -10, -10, -10, -10, -10, -24};

  function automatic logic [1:0] exp_act(int s, int hi, int lo);
`ifdef TERNARY_NEURON_TERNARY_ACT_EN
    if (s > hi) return 2'b01;
    if (s < lo) return 2'b11;
    return 2'b00;
`else
    if (s >= hi) return 2'b01;
    return 2'b00;
`endif
  endfunction

  task automatic set_thr(input int hi, input int lo);
    thr_hi_i   = hi;
    thr_lo_i   = lo;
    bus.thr_hi = ACC_W'(hi);
    bus.thr_lo = ACC_W'(lo);
  endtask

  // Drives n beats from bp/bn; a full neuron pushes its expectation.
  task automatic send(input int n, input int gap);
    int s;
    int t;
    logic signed [ACC_W-1:0] w;
    s = 0;
    for (int i = 0; i < n; i++) begin
      if (gap > 0) begin
        bus.in_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      bus.in_valid = 1'b1;
      bus.pos_cnt  = CNT_W'(bp[i]);
      bus.neg_cnt  = CNT_W'(bn[i]);
      t = 0;
      while (bus.in_ready !== 1'b1 && t < 20) begin
        @(posedge clk);
        #1;
        t++;
      end
      if (t == 20) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout beat=%0d", i);
      end
      @(posedge clk);
      #1;
      s += bp[i] - bn[i];
    end
    bus.in_valid = 1'b0;
    if (n == BEATS) begin
      w = ACC_W'(s);
      sb.push_back({exp_act(int'(w), thr_hi_i, thr_lo_i), w});
    end
  endtask

  task automatic load(input int c);
    for (int i = 0; i < BEATS; i++) begin
      bp[i] = case_p[c][i];
      bn[i] = case_n[c][i];
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_in_ready got=%b want=1", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_valid got=%b want=0", bus.out_valid);
    end
    checks++;
    if (bus.act !== 2'b00) begin
      errors++;
      $display("FAIL rst_act got=%b want=00", bus.act);
    end
    checks++;
    if (bus.acc_out !== '0) begin
      errors++;
      $display("FAIL rst_acc_out got=%0d want=0", bus.acc_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_cases;
    logic [9:0] e;
    bus.out_ready = 1'b1;
    for (int c = 0; c < NCASE; c++) begin
      set_thr(case_hi[c], case_lo[c]);
      load(c);
      send(BEATS, 0);
      e = sb.pop_front();
      if (c == 0) bb_ref = e;
      checks++;
      if (bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL case%0d_latency out_valid=%b want=1",
                 c, bus.out_valid);
      end
      checks++;
      if ({bus.act, bus.acc_out} !== e) begin
        errors++;
        $display("FAIL case%0d_result act=%b acc=%0d want act=%b acc=%0d",
                 c, bus.act, $signed(bus.acc_out),
                 e[9:8], $signed(e[7:0]));
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL case%0d_release in_ready=%b out_valid=%b want 1/0",
                 c, bus.in_ready, bus.out_valid);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] e;
    int t;
    bus.out_ready = 1'b1;
    set_thr(10, -10);
    fork
      begin
        load(0);
        send(BEATS, 0);
        load(1);
        send(BEATS, 0);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          t = 0;
          @(posedge clk);
          #2;
          while (bus.out_valid !== 1'b1 && t < 40) begin
            @(posedge clk);
            #2;
            t++;
          end
          checks++;
          if (t == 40) begin
            errors++;
            $display("FAIL b2b%0d_timeout out_valid never rose", k);
          end else begin
            e = sb.pop_front();
            if ({bus.act, bus.acc_out} !== e) begin
              errors++;
              $display("FAIL b2b%0d_result act=%b acc=%0d want act=%b acc=%0d",
                       k, bus.act, $signed(bus.acc_out),
                       e[9:8], $signed(e[7:0]));
            end
          end
        end
      end
    join
    @(posedge clk);
    #1;
  endtask

  task automatic test_gaps;
    logic [9:0] e;
    bus.out_ready = 1'b1;
    set_thr(10, -10);
    load(0);
    send(BEATS, 2);
    e = sb.pop_front();
    checks++;
    if ({bus.out_valid, bus.act, bus.acc_out} !== {1'b1, e}) begin
      errors++;
      $display("FAIL gaps_result v=%b act=%b acc=%0d want act=%b acc=%0d",
               bus.out_valid, bus.act, $signed(bus.acc_out),
               e[9:8], $signed(e[7:0]));
    end
    checks++;
    if ({bus.act, bus.acc_out} !== bb_ref) begin
      errors++;
      $display("FAIL gaps_vs_b2b act=%b acc=%0d want act=%b acc=%0d",
               bus.act, $signed(bus.acc_out),
               bb_ref[9:8], $signed(bb_ref[7:0]));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_stall;
    logic [9:0] e;
    bus.out_ready = 1'b0;
    set_thr(10, -10);
    load(0);
    send(BEATS, 0);
    e = sb.pop_front();
    set_thr(127, -128);
    bus.in_valid = 1'b1;
    bus.pos_cnt  = 5'd31;
    bus.neg_cnt  = 5'd0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall%0d_out_valid got=%b want=1", k, bus.out_valid);
      end
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall%0d_in_ready got=%b want=0", k, bus.in_ready);
      end
      checks++;
      if ({bus.act, bus.acc_out} !== e) begin
        errors++;
        $display("FAIL stall%0d_hold act=%b acc=%0d want act=%b acc=%0d",
                 k, bus.act, $signed(bus.acc_out),
                 e[9:8], $signed(e[7:0]));
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release in_ready=%b out_valid=%b want 1/0",
               bus.in_ready, bus.out_valid);
    end
    set_thr(10, -10);
  endtask

  task automatic test_reset_mid;
    logic [9:0] e;
    bus.out_ready = 1'b1;
    set_thr(10, -10);
    load(5);
    send(2, 0);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.act, bus.acc_out}
        !== {1'b1, 1'b0, 2'b00, 8'd0}) begin
      errors++;
      $display("FAIL midrst_outputs rdy=%b v=%b act=%b acc=%0d want 1/0/00/0",
               bus.in_ready, bus.out_valid, bus.act, $signed(bus.acc_out));
    end
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(BEATS, 0);
    e = sb.pop_front();
    checks++;
    if ({bus.out_valid, bus.act, bus.acc_out} !== {1'b1, e}) begin
      errors++;
      $display("FAIL midrst_result v=%b act=%b acc=%0d want act=%b acc=%0d",
               bus.out_valid, bus.act, $signed(bus.acc_out),
               e[9:8], $signed(e[7:0]));
    end
    checks++;
    if (e !== {2'b01, 8'd124}) begin
      errors++;
      $display("FAIL midrst_model exp=%h want=%h", e, {2'b01, 8'd124});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.pos_cnt   = '0;
    bus.neg_cnt   = '0;
    bus.out_ready = 1'b1;
    set_thr(10, -10);
    test_reset();
    test_cases();
    test_back_to_back();
    test_gaps();
    test_stall();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ternary_neuron_acc.md
# ternary_neuron_acc

Sequential accumulate-and-activate stage for printed ternary neurons, directly downstream of the 25-input popcount blocks. Each accepted beat carries two 5-bit popcounts, one for positive-weight inputs and one for negative-weight inputs. The block accumulates their signed difference over BEATS beats, so a neuron with fan-in up to 25×BEATS per polarity can be evaluated. It then compares the sum against programmable thresholds and emits a ternary activation through a valid/ready handshake.

## Interface
- BEATS, 4: beats accumulated per neuron evaluation; must be ≥1.
- CNT_W, 5: width of each popcount input, matching the popcount25 output.
- ACC_W, 8: signed accumulator width; must hold ±BEATS×(2^CNT_W−1). The default holds ±124.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- pos_cnt  in  CNT_W  popcount of positive-weight inputs (unsigned).
- neg_cnt  in  CNT_W  popcount of negative-weight inputs (unsigned).
- thr_hi  in  ACC_W  signed upper threshold.
- thr_lo  in  ACC_W  signed lower threshold; software guarantees thr_lo ≤ thr_hi.
- out_valid  out  1  activation valid.
- out_ready  in  1  consumer accepts the activation.
- act  out  2  activation: 2'b01 = +1, 2'b00 = 0, 2'b11 = −1.
- acc_out  out  ACC_W  final signed sum, for debug and verification.

## Operation
- FSM has two states: ACC and OUT. Reset state is ACC.
- ACC:
  - in_ready = 1.
  - On in_valid&&in_ready: acc ← acc + (zero-extend(pos_cnt) − zero-extend(neg_cnt)), sign-extended to ACC_W. beat_cnt increments.
  - On the BEATS-th accepted beat, the final sum is computed from that beat's data.
  - acc_out and act are registered, and the FSM moves to OUT.
  - acc and beat_cnt clear in the same cycle.
- OUT:
  - in_ready = 0 and out_valid = 1.
  - act and acc_out are held stable until out_valid&&out_ready, then the FSM returns to ACC.
- Activation rules:
  - act = +1 if sum > thr_hi.
  - act = −1 if sum < thr_lo.
  - act = 0 otherwise.
  - Comparisons are signed over ACC_W bits.
- Thresholds are sampled combinationally on the cycle the last beat is accepted. Changes at any other time have no effect on the current result.
- Accumulation wraps modulo 2^ACC_W and does not saturate. ACC_W sizing is the integrator's responsibility.
- pos_cnt/neg_cnt values up to 2^CNT_W−1 are legal. Approximate popcounts may exceed 25, and the block applies no clamping.
- BEATS=1: every accepted beat produces a result.
- Reset mid-operation discards the partial sum and any pending output.

## Timing
- Reset values: in_ready=1, out_valid=0, act=2'b00, acc_out=0, acc=0, beat_cnt=0, state=ACC.
- Latency: out_valid rises on the clock edge that accepts the last beat, i.e. visible the next cycle.
- Throughput: at best BEATS+1 cycles per neuron, since no beat is accepted while in OUT.
- in_ready depends only on state; it has no combinational path from out_ready.
- out_valid, act and acc_out are driven directly from flops.
- in_valid low in ACC: acc and beat_cnt hold. Gaps between beats are legal.

## Configuration
- TERNARY_NEURON_TERNARY_ACT_EN defined: full ternary activation as described above.
- Undefined: binary sign activation.
  - act = 2'b01 if sum ≥ thr_hi, else 2'b00.
  - thr_lo is ignored and the lower comparator is not built.
  - act[1] is tied to 0.

## Structure
- Package ternary_nn_pkg holds:
  - localparams ACT_POS=2'b01, ACT_ZERO=2'b00, ACT_NEG=2'b11;
  - the state enum {ST_ACC, ST_OUT};
  - a function for the signed delta of two popcounts.
- Sub-module ternary_act_cmp: purely combinational sum-vs-threshold comparator, parameterised by ACC_W. The TERNARY_NEURON_TERNARY_ACT_EN macro lives here.

## Test plan
- Reset, BEATS=4, thr_hi=10, thr_lo=−10; send 4 beats with (pos,neg)=(20,5) and out_ready=1. Expected: sum 60, act=01, acc_out=60, out_valid one cycle after the 4th accept.
- Same thresholds; 4 beats of (3,9). Expected: sum −24, act=11.
- 4 beats (7,7),(8,6),(5,9),(2,0). Expected: sum 0, act=00. With the macro undefined and thr_hi=0, act=01.
- Hold out_ready=0 for 5 cycles after the result. Expected: out_valid stays 1, act/acc_out stable, in_ready=0. Release out_ready, then in_ready=1 the next cycle.
- Insert in_valid gaps between beats. Expected: result identical to the back-to-back run.
- Assert rst after 2 of 4 beats (asynchronously, mid-cycle). Expected: outputs immediately return to reset values, and the next 4 beats of (31,0) give sum 124 and act=01.
